// File: rtl/mult_pipe_hs_if.sv
// Valid/ready operand and product channels of the pipelined multiplier.
// The master side issues operands and consumes products; the slave side is the multiplier.
interface mult_pipe_hs_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/mult_pipe_hs.sv
// Three-stage WIDTH x WIDTH multiplier with per-operation signed/unsigned mode,
// carry-save partial-product reduction and a Kogge-Stone final adder.
module mult_pipe_hs #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst,
  mult_pipe_hs_if.slave bus
);
  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = $clog2(PW);

  logic             v1, v2, v3;
  logic [WIDTH-1:0] a1, b1;
  logic             sgn1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [PW-1:0]    sum2, carry2, prod3;
  logic             adv;

  logic [PW-1:0]    a_ext, pp_row, csa_s, csa_c, csa_s_nxt, csa_c_nxt;
  logic [PW-1:0]    pf_g, pf_p, pf_g_nxt, pf_p_nxt, adder_out;

  assign adv             = !v3 || bus.out_ready;
  assign bus.in_ready    = adv && !rst;
  assign bus.out_valid   = v3;
  assign bus.out_product = prod3;
  assign bus.out_tag     = tag3;

  // In signed mode the multiplier MSB has negative weight, so that row is added
  // as its one's complement followed by a +1 correction row.
  always_comb begin
    a_ext     = sgn1 ? {{WIDTH{a1[WIDTH-1]}}, a1} : {{WIDTH{1'b0}}, a1};
    csa_s     = '0;
    csa_c     = '0;
    pp_row    = '0;
    csa_s_nxt = '0;
    csa_c_nxt = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i == WIDTH)
        pp_row = (sgn1 && b1[WIDTH-1]) ? PW'(1) : '0;
      else if (sgn1 && i == WIDTH - 1)
        pp_row = b1[i] ? ~(a_ext << i) : '0;
      else
        pp_row = b1[i] ? (a_ext << i) : '0;
      csa_s_nxt = csa_s ^ csa_c ^ pp_row;
      csa_c_nxt = ((csa_s & csa_c) | (csa_s & pp_row) | (csa_c & pp_row)) << 1;
      csa_s     = csa_s_nxt;
      csa_c     = csa_c_nxt;
    end
  end

  always_comb begin
    pf_g     = sum2 & carry2;
    pf_p     = sum2 ^ carry2;
    pf_g_nxt = '0;
    pf_p_nxt = '0;
    for (int l = 0; l < LEVELS; l++) begin
      pf_g_nxt = pf_g;
      pf_p_nxt = pf_p;
      for (int i = (1 << l); i < PW; i++) begin
        pf_g_nxt[i] = pf_g[i] | (pf_p[i] & pf_g[i - (1 << l)]);
        pf_p_nxt[i] = pf_p[i] & pf_p[i - (1 << l)];
      end
      pf_g = pf_g_nxt;
      pf_p = pf_p_nxt;
    end
    adder_out = (sum2 ^ carry2) ^ {pf_g[PW-2:0], 1'b0};
  end

  // The whole pipe shifts together or holds together; bubbles travel with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      sgn1   <= 1'b0;
      tag1   <= '0;
      tag2   <= '0;
      tag3   <= '0;
      sum2   <= '0;
      carry2 <= '0;
      prod3  <= '0;
    end else if (adv) begin
      v1     <= bus.in_valid;
      a1     <= bus.in_a;
      b1     <= bus.in_b;
      sgn1   <= bus.in_signed;
      tag1   <= bus.in_tag;
      v2     <= v1;
      sum2   <= csa_s;
      carry2 <= csa_c;
      tag2   <= tag1;
      v3     <= v2;
      prod3  <= adder_out;
      tag3   <= tag2;
    end
  end
endmodule

// File: tb/tb_mult_pipe_hs.sv
// Bench for mult_pipe_hs: directed WIDTH=8 scenarios plus WIDTH=4 exhaustive and
// WIDTH=16 randomized traffic, all checked against an arithmetic reference model.
module tb_mult_pipe_hs;
  localparam int TW = 4;

  logic clk;
  logic rst;
  logic rst_r;
  int   compareCount;
  int   mismatchCount;

  localparam logic [7:0]  DIR_A [4] = '{8'h80, 8'h80, 8'hFF, 8'h7F};
  localparam logic [7:0]  DIR_B [4] = '{8'h80, 8'h80, 8'h01, 8'h80};
  localparam logic        DIR_S [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [15:0] DIR_P [4] = '{16'h4000, 16'h4000, 16'hFFFF, 16'hC080};

  mult_pipe_hs_if #(.WIDTH(8), .TAG_W(TW)) if8 ();
  mult_pipe_hs #(.WIDTH(8), .TAG_W(TW)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference product: plain integer multiply of the operands interpreted per mode.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn, input int w);
    longint sa, sb;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sa * sb) & mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic sgn, input logic [TW-1:0] tag);
    if8.in_valid  = valid;
    if8.in_a      = a;
    if8.in_b      = b;
    if8.in_signed = sgn;
    if8.in_tag    = tag;
  endtask

  // Randomized traffic engines: WIDTH=4 walks every operand pair in both modes,
  // WIDTH=16 issues random operands; both use random valid and ready gaps.
  for (genvar k = 0; k < 2; k++) begin : g_rand
    localparam int W      = (k == 0) ? 4 : 16;
    localparam int N      = (k == 0) ? 512 : 10000;
    localparam bit EXH    = (k == 0);
    localparam int BUDGET = 60000;

    mult_pipe_hs_if #(.WIDTH(W), .TAG_W(TW)) rbus ();
    mult_pipe_hs #(.WIDTH(W), .TAG_W(TW)) u_dut (.clk(clk), .rst(rst_r), .bus(rbus));

    logic [63:0]   expQ [$];
    logic [TW-1:0] tagQ [$];
    logic [W-1:0]  ra, rb;
    logic          rs;
    logic          pend;
    logic          done;
    int            sent, rcvd, cyc;

    initial begin
      done = 1'b0;
      pend = 1'b0;
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      rbus.in_valid  = 1'b0;
      rbus.in_a      = '0;
      rbus.in_b      = '0;
      rbus.in_signed = 1'b0;
      rbus.in_tag    = '0;
      rbus.out_ready = 1'b0;
      @(negedge clk);
      while (rst_r) @(negedge clk);
      while (rcvd < N && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        if (!pend) begin
          if (sent < N && $urandom_range(0, 3) != 0) begin
            if (EXH) begin
              ra = W'(sent);
              rb = W'(sent >> W);
              rs = 1'(sent >> (2 * W));
            end else begin
              ra = W'($urandom);
              rb = W'($urandom);
              if ($urandom_range(0, 7) == 0) ra = {1'b1, {(W-1){1'b0}}};
              if ($urandom_range(0, 7) == 0) rb = {1'b1, {(W-1){1'b0}}};
              rs = 1'($urandom_range(0, 1));
            end
            rbus.in_a      = ra;
            rbus.in_b      = rb;
            rbus.in_signed = rs;
            rbus.in_tag    = TW'(sent);
            rbus.in_valid  = 1'b1;
            pend = 1'b1;
          end else begin
            rbus.in_valid = 1'b0;
          end
        end
        rbus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (rbus.in_valid && rbus.in_ready) begin
          expQ.push_back(refProduct(32'(ra), 32'(rb), rs, W));
          tagQ.push_back(TW'(sent));
          sent++;
          pend = 1'b0;
        end
        if (rbus.out_valid && rbus.out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("W%0d spurious out_valid", W), 64'(rbus.out_valid), 64'd0);
          end else begin
            checkOutput($sformatf("W%0d product #%0d", W, rcvd), 64'(rbus.out_product),
                        expQ.pop_front());
            checkOutput($sformatf("W%0d tag #%0d", W, rcvd), 64'(rbus.out_tag),
                        64'(tagQ.pop_front()));
            rcvd++;
          end
        end
      end
      rbus.in_valid = 1'b0;
      checkOutput($sformatf("W%0d results received", W), 64'(rcvd), 64'(N));
      done = 1'b1;
    end
  end

  initial begin
    int opIdx;
    int nOut;
    compareCount  = 0;
    mismatchCount = 0;
    rst   = 1'b1;
    rst_r = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    if8.out_ready = 1'b0;

    // Reset behaviour: not ready while held, clean outputs once released.
    repeat (3) @(negedge clk);
    #1 checkOutput("in_ready during reset", 64'(if8.in_ready), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    rst_r = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(if8.out_valid), 64'd0);
    checkOutput("reset out_product", 64'(if8.out_product), 64'd0);
    checkOutput("reset out_tag", 64'(if8.out_tag), 64'd0);
    checkOutput("in_ready after reset", 64'(if8.in_ready), 64'd1);

    // Unsigned 255*255 with exact three-cycle latency.
    @(negedge clk);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 4'h5);
    if8.out_ready = 1'b1;
    #1 checkOutput("u255 accepted", 64'(if8.in_ready), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      #1 checkOutput($sformatf("u255 out_valid cycle %0d", c), 64'(if8.out_valid), 64'(c == 3));
    end
    checkOutput("u255 product", 64'(if8.out_product), 64'hFE01);
    checkOutput("u255 tag", 64'(if8.out_tag), 64'h5);
    @(negedge clk);
    #1 checkOutput("u255 drained", 64'(if8.out_valid), 64'd0);

    // Signed corners interleaved with an unsigned op, back to back.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 4) applyStimulus(1'b1, DIR_A[c], DIR_B[c], DIR_S[c], TW'(c + 1));
      else       applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      #1;
      if (c >= 3) begin
        checkOutput($sformatf("b2b out_valid %0d", c - 3), 64'(if8.out_valid), 64'd1);
        checkOutput($sformatf("b2b product %0d", c - 3), 64'(if8.out_product), 64'(DIR_P[c-3]));
        checkOutput($sformatf("b2b tag %0d", c - 3), 64'(if8.out_tag), 64'(c - 2));
      end
    end
    @(negedge clk);
    #1 checkOutput("b2b drained", 64'(if8.out_valid), 64'd0);

    // Backpressure: consumer stalls five cycles while four ops are queued.
    opIdx = 0;
    nOut  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (opIdx < 4)
        applyStimulus(1'b1, 8'(3 * (opIdx + 1)), 8'(opIdx + 11), 1'b0, TW'(opIdx + 1));
      else
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      if8.out_ready = (c >= 5);
      #1;
      if (c == 3 || c == 4) begin
        checkOutput($sformatf("bp in_ready stalled %0d", c), 64'(if8.in_ready), 64'd0);
        checkOutput($sformatf("bp held tag %0d", c), 64'(if8.out_tag), 64'd1);
        checkOutput($sformatf("bp held product %0d", c), 64'(if8.out_product), 64'd33);
      end
      if (if8.in_valid && if8.in_ready) opIdx++;
      if (if8.out_valid && if8.out_ready) begin
        checkOutput($sformatf("bp order tag %0d", nOut), 64'(if8.out_tag), 64'(nOut + 1));
        checkOutput($sformatf("bp order product %0d", nOut), 64'(if8.out_product),
                    refProduct(32'(3 * (nOut + 1)), 32'(nOut + 11), 1'b0, 8));
        nOut++;
      end
    end
    checkOutput("bp results delivered", 64'(nOut), 64'd4);

    // Reset with three ops in flight: none of them may ever be delivered.
    if8.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'(c + 7), 8'(c + 9), 1'b1, TW'(c + 10));
      #1 checkOutput($sformatf("rst-mid accept %0d", c), 64'(if8.in_ready), 64'd1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    rst = 1'b1;
    #1 checkOutput("rst-mid in_ready", 64'(if8.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if8.out_ready = 1'b1;
    #1;
    checkOutput("rst-mid out_valid", 64'(if8.out_valid), 64'd0);
    checkOutput("rst-mid out_product", 64'(if8.out_product), 64'd0);
    checkOutput("rst-mid out_tag", 64'(if8.out_tag), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("rst-mid nothing emerges %0d", c), 64'(if8.out_valid), 64'd0);
    end

    for (int c = 0; c < 70000 && !(g_rand[0].done && g_rand[1].done); c++) @(negedge clk);
    checkOutput("random traffic finished", 64'(g_rand[0].done && g_rand[1].done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
